// File: rtl/seven_segment_capture.sv
// seven_segment_capture
// Reader for a multiplexed, active-low seven-segment bus. Each strobe samples
// {an_in, seg_in}. When one anode is active and the same pattern has been seen
// on STABLE_CNT consecutive strobes, the pattern is committed to that digit
// position and decoded back to a hex nibble. It also tracks frame completion
// and raises a stall flag when the scan stops producing commits.

module seven_segment_capture #(
   parameter int NUM_DIGITS   = 4,
   parameter int STABLE_CNT   = 4,    // must be >= 2
   parameter int SCAN_TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sample_en,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   output logic [4*NUM_DIGITS-1:0] digit_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic [NUM_DIGITS-1:0]   invalid,
   output logic                    frame_done,
   output logic                    stalled
);

   // Counter widths are sized so that the terminal values fit exactly.
   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam int TW = $clog2(SCAN_TIMEOUT + 1);

   localparam logic [CW-1:0] STAB_FULL = CW'(STABLE_CNT);
   localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CNT - 1);
   localparam logic [CW-1:0] STAB_ONE  = CW'(1);
   localparam logic [TW-1:0] TMO_FULL  = TW'(SCAN_TIMEOUT);
   localparam logic [TW-1:0] TMO_ONE   = TW'(1);

   localparam logic [6:0]            SEG_BLANK = 7'h7F;
   localparam logic [NUM_DIGITS-1:0] AN_IDLE   = '1;
   localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

   // Result of looking a segment pattern up in the hex glyph table.
   typedef struct packed {
      logic       hit;       // pattern is one of the 16 hex glyphs
      logic       is_blank;  // all segments off
      logic [3:0] value;     // decoded nibble, meaningful only on hit
   } decode_t;

   // Active-low glyph table, bit0 = segment a ... bit6 = segment g.
   function automatic decode_t decode_seg(input logic [6:0] seg);
      decode_t d;
      d.hit      = 1'b1;
      d.is_blank = 1'b0;
      d.value    = 4'h0;
      case (seg)
         7'h40:   d.value = 4'h0;
         7'h79:   d.value = 4'h1;
         7'h24:   d.value = 4'h2;
         7'h30:   d.value = 4'h3;
         7'h19:   d.value = 4'h4;
         7'h12:   d.value = 4'h5;
         7'h02:   d.value = 4'h6;
         7'h78:   d.value = 4'h7;
         7'h00:   d.value = 4'h8;
         7'h10:   d.value = 4'h9;
         7'h08:   d.value = 4'hA;
         7'h03:   d.value = 4'hB;
         7'h46:   d.value = 4'hC;
         7'h21:   d.value = 4'hD;
         7'h06:   d.value = 4'hE;
         7'h0E:   d.value = 4'hF;
         SEG_BLANK: begin
            d.hit      = 1'b0;
            d.is_blank = 1'b1;
         end
         default: d.hit = 1'b0;
      endcase
      return d;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [NUM_DIGITS-1:0]      prev_an_q,    prev_an_d;
   logic [6:0]                 prev_seg_q,   prev_seg_d;
   logic [CW-1:0]              stab_cnt_q,   stab_cnt_d;
   logic [NUM_DIGITS-1:0]      mask_q,       mask_d;
   logic [TW-1:0]              tmo_cnt_q,    tmo_cnt_d;
   logic [NUM_DIGITS-1:0][3:0] digit_q,      digit_d;
   logic [NUM_DIGITS-1:0]      valid_q,      valid_d;
   logic [NUM_DIGITS-1:0]      blank_q,      blank_d;
   logic [NUM_DIGITS-1:0]      invalid_q,    invalid_d;
   logic                       frame_done_q, frame_done_d;
   logic                       stalled_q,    stalled_d;

   // Per-strobe qualification results
   logic [NUM_DIGITS-1:0] sel;           // one-hot active digit (active-high)
   logic                  digit_active;  // exactly one anode low
   logic                  same_sample;   // bus matches the previous strobe
   logic                  commit;        // this strobe completes a stable run
   decode_t               dec;

   // Qualify the current bus sample and decide whether it commits.
   always_comb begin
      sel          = ~an_in;
      // A single set bit clears when ANDed with itself minus one.
      digit_active = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
      same_sample  = ({an_in, seg_in} == {prev_an_q, prev_seg_q});
      // Commit fires only on the STABLE_CNT-1 -> STABLE_CNT step; the
      // saturated count never matches again, so a held pattern commits once.
      commit       = sample_en && digit_active && same_sample &&
                     (stab_cnt_q == STAB_LAST);
      dec          = decode_seg(seg_in);
   end

   // Track the previous sample and the run length of identical samples.
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so a
      // path that skips an assignment holds the flop value instead of
      // inferring a latch.
      prev_an_d  = prev_an_q;
      prev_seg_d = prev_seg_q;
      stab_cnt_d = stab_cnt_q;
      if (sample_en) begin
         prev_an_d  = an_in;
         prev_seg_d = seg_in;
         if (!digit_active) begin
            stab_cnt_d = '0;
         end else if (same_sample) begin
            if (stab_cnt_q != STAB_FULL) begin
               stab_cnt_d = stab_cnt_q + STAB_ONE;
            end
         end else begin
            stab_cnt_d = STAB_ONE;
         end
      end
   end

   // Apply commits to the per-digit outputs, the frame mask and the stall timer.
   always_comb begin
      digit_d      = digit_q;
      valid_d      = valid_q;
      blank_d      = blank_q;
      invalid_d    = invalid_q;
      mask_d       = mask_q;
      tmo_cnt_d    = tmo_cnt_q;
      stalled_d    = stalled_q;
      frame_done_d = 1'b0;

      if (commit) begin
         tmo_cnt_d = '0;
         stalled_d = 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
               if (dec.hit) begin
                  digit_d[i]   = dec.value;
                  valid_d[i]   = 1'b1;
                  blank_d[i]   = 1'b0;
                  invalid_d[i] = 1'b0;
               end else if (dec.is_blank) begin
                  digit_d[i]   = 4'h0;
                  valid_d[i]   = 1'b0;
                  blank_d[i]   = 1'b1;
                  invalid_d[i] = 1'b0;
               end else begin
                  // Unknown glyph: keep the last good nibble for inspection.
                  valid_d[i]   = 1'b0;
                  blank_d[i]   = 1'b0;
                  invalid_d[i] = 1'b1;
               end
            end
         end
         // Any kind of commit counts toward the frame.
         mask_d = mask_q | sel;
         if (&mask_d) begin
            frame_done_d = 1'b1;
            mask_d       = '0;
         end
      end else if (sample_en && (tmo_cnt_q != TMO_FULL)) begin
         // Timer holds once it reaches the limit until the next commit.
         tmo_cnt_d = tmo_cnt_q + TMO_ONE;
         if (tmo_cnt_d == TMO_FULL) begin
            stalled_d = 1'b1;
            valid_d   = '0;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // The previous-sample register resets to the idle bus (no anode,
         // all segments off) so the first real strobe always starts a run.
         prev_an_q    <= AN_IDLE;
         prev_seg_q   <= SEG_BLANK;
         stab_cnt_q   <= '0;
         mask_q       <= '0;
         tmo_cnt_q    <= '0;
         digit_q      <= '0;
         valid_q      <= '0;
         blank_q      <= '0;
         invalid_q    <= '0;
         frame_done_q <= 1'b0;
         stalled_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge value of the others, independent of statement order.
         prev_an_q    <= prev_an_d;
         prev_seg_q   <= prev_seg_d;
         stab_cnt_q   <= stab_cnt_d;
         mask_q       <= mask_d;
         tmo_cnt_q    <= tmo_cnt_d;
         digit_q      <= digit_d;
         valid_q      <= valid_d;
         blank_q      <= blank_d;
         invalid_q    <= invalid_d;
         frame_done_q <= frame_done_d;
         stalled_q    <= stalled_d;
      end
   end

   assign digit_out   = digit_q;
   assign digit_valid = valid_q;
   assign blank       = blank_q;
   assign invalid     = invalid_q;
   assign frame_done  = frame_done_q;
   assign stalled     = stalled_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture
// Directed bench for seven_segment_capture. Each strobe pushes the expected
// output snapshot onto a scoreboard queue; the snapshot is popped and compared
// one clock later, when the registered outputs reflect that strobe.

module tb_seven_segment_capture;

   localparam int ND  = 4;
   localparam int TMO = 1024;

   logic            clk;
   logic            rst_n;
   logic            sample_en;
   logic [6:0]      seg_in;
   logic [ND-1:0]   an_in;
   logic [4*ND-1:0] digit_out;
   logic [ND-1:0]   digit_valid;
   logic [ND-1:0]   blank;
   logic [ND-1:0]   invalid;
   logic            frame_done;
   logic            stalled;

   seven_segment_capture #(
      .NUM_DIGITS  (ND),
      .STABLE_CNT  (4),
      .SCAN_TIMEOUT(TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .seg_in     (seg_in),
      .an_in      (an_in),
      .digit_out  (digit_out),
      .digit_valid(digit_valid),
      .blank      (blank),
      .invalid    (invalid),
      .frame_done (frame_done),
      .stalled    (stalled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] digit;
      logic [3:0]  valid;
      logic [3:0]  blnk;
      logic [3:0]  inval;
      logic        fd;
      logic        st;
   } exp_t;

   exp_t exp_q[$];

   int n_vec  = 0;
   int n_miss = 0;

   // Reference glyph table: entry v is the active-low pattern for hex digit v.
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Expected output state
   logic [15:0] m_digit;
   logic [3:0]  m_valid, m_blank, m_invalid, m_mask;
   logic        m_stalled;
   int          m_tmo;

   task automatic model_reset();
      m_digit   = '0;
      m_valid   = '0;
      m_blank   = '0;
      m_invalid = '0;
      m_mask    = '0;
      m_stalled = 1'b0;
      m_tmo     = 0;
   endtask

   task automatic push_expect(input logic fd);
      exp_t e;
      e.digit = m_digit;
      e.valid = m_valid;
      e.blnk  = m_blank;
      e.inval = m_invalid;
      e.fd    = fd;
      e.st    = m_stalled;
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_pop(input string tag);
      exp_t e;
      n_vec++;
      assert (exp_q.size() != 0) else begin
         n_miss++;
         $error("FAIL %s: observed empty scoreboard expected one entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         cmp({tag, ".digit_out"},   32'(digit_out),   32'(e.digit));
         cmp({tag, ".digit_valid"}, 32'(digit_valid), 32'(e.valid));
         cmp({tag, ".blank"},       32'(blank),       32'(e.blnk));
         cmp({tag, ".invalid"},     32'(invalid),     32'(e.inval));
         cmp({tag, ".frame_done"},  32'(frame_done),  32'(e.fd));
         cmp({tag, ".stalled"},     32'(stalled),     32'(e.st));
      end
   endtask

   // One strobe. is_commit is the directed expectation that this strobe
   // completes a stable run; the model then derives the resulting outputs.
   task automatic strobe(input string tag, input logic [3:0] an, input logic [6:0] seg,
                         input bit is_commit);
      int   idx;
      bit   hit;
      logic fd;
      @(negedge clk);
      sample_en = 1'b1;
      an_in     = an;
      seg_in    = seg;
      fd        = 1'b0;
      if (is_commit) begin
         idx = 0;
         for (int i = 0; i < ND; i++) if (!an[i]) idx = i;
         hit = 1'b0;
         for (int v = 0; v < 16; v++) begin
            if (seg_tab[v] == seg) begin
               hit = 1'b1;
               m_digit[idx*4 +: 4] = 4'(v);
            end
         end
         if (hit) begin
            m_valid[idx] = 1'b1; m_blank[idx] = 1'b0; m_invalid[idx] = 1'b0;
         end else if (seg == 7'h7F) begin
            m_digit[idx*4 +: 4] = 4'h0;
            m_valid[idx] = 1'b0; m_blank[idx] = 1'b1; m_invalid[idx] = 1'b0;
         end else begin
            m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; m_invalid[idx] = 1'b1;
         end
         m_tmo        = 0;
         m_stalled    = 1'b0;
         m_mask[idx]  = 1'b1;
         if (m_mask == 4'hF) begin
            fd     = 1'b1;
            m_mask = 4'h0;
         end
      end else if (m_tmo < TMO) begin
         m_tmo++;
         if (m_tmo == TMO) begin
            m_stalled = 1'b1;
            m_valid   = '0;
         end
      end
      push_expect(fd);
      @(posedge clk);
      #1;
      sample_en = 1'b0;
      check_pop(tag);
   endtask

   // n strobes of one pattern; commit_at is the 1-based strobe expected to commit (0 = none).
   task automatic run(input string tag, input logic [3:0] an, input logic [6:0] seg,
                      input int n, input int commit_at);
      for (int k = 1; k <= n; k++) strobe(tag, an, seg, k == commit_at);
   endtask

   // Asynchronous reset with a strobe held active throughout, which must be ignored.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n     = 1'b0;
      sample_en = 1'b1;
      an_in     = 4'b1110;
      seg_in    = 7'h40;
      #1;
      model_reset();
      push_expect(1'b0);
      check_pop(tag);
      repeat (3) @(negedge clk);
      sample_en = 1'b0;
      an_in     = 4'b1111;
      seg_in    = 7'h7F;
      rst_n     = 1'b1;
   endtask

   logic [3:0] scan_an  [10] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101,
                                 4'b1110, 4'b1101, 4'b1011, 4'b0111,
                                 4'b1110, 4'b1101};
   logic [6:0] scan_seg [10] = '{7'h08, 7'h03, 7'h46, 7'h21,
                                 7'h12, 7'h78, 7'h00, 7'h10,
                                 7'h06, 7'h0E};

   initial begin
      rst_n     = 1'b0;
      sample_en = 1'b0;
      an_in     = 4'b1111;
      seg_in    = 7'h7F;
      model_reset();

      // Power-on reset state
      do_reset("reset");

      // Stable digit 0 = '0', then 10 held strobes with no re-commit
      run("stable", 4'b1110, 7'h40, 14, 4);

      // Full scan 1,2,3,4; frame completes on digit 3
      run("scan_d0", 4'b1110, 7'h79, 4, 4);
      run("scan_d1", 4'b1101, 7'h24, 4, 4);
      run("scan_d2", 4'b1011, 7'h30, 4, 4);
      run("scan_d3", 4'b0111, 7'h19, 4, 4);
      cmp("scan_value", 32'(digit_out), 32'h4321);

      // Glitch: two runs of three are each one short of a commit
      run("glitch_a", 4'b1110, 7'h12, 3, 0);
      run("glitch_b", 4'b1110, 7'h02, 3, 0);
      // Fourth equal sample of the second run is the boundary that commits
      run("glitch_c", 4'b1110, 7'h02, 1, 1);

      // Two anodes low: never qualifies
      run("two_an", 4'b1100, 7'h40, 8, 0);
      // Unrecognised glyph keeps nibble 2, then blank clears it
      run("inval_d1", 4'b1101, 7'h55, 4, 4);
      run("blank_d1", 4'b1101, 7'h7F, 4, 4);

      // No active anode until the stall limit is reached, then recover
      run("idle", 4'b1111, 7'h7F, TMO, 0);
      cmp("stall_flag", 32'(stalled), 32'h1);
      run("recover_d2", 4'b1011, 7'h30, 4, 4);
      cmp("recover_valid", 32'(digit_valid), 32'h4);

      // Partial frame (repeat commits of digits 0 and 1), then reset mid-frame
      run("pre_rst_d0", 4'b1110, 7'h40, 4, 4);
      run("pre_rst_d1", 4'b1101, 7'h24, 4, 4);
      do_reset("mid_reset");

      // Scan order 2,3,0,1 then further frames covering the rest of the table
      for (int s = 0; s < 10; s++) begin
         run($sformatf("post_rst_%0d", s), scan_an[s], scan_seg[s], 4, 4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
